// File: rtl/predictor_mac_pkg.sv
// Shared widths and the round / shift / saturate step for the predictor MAC.
package predictor_mac_pkg;

    localparam int PRED_A_W   = 29;
    localparam int PRED_B_W   = 64;
    localparam int PRED_ACC_W = 100;

    // Working width for the output step; must exceed any ACC_W in use by a few bits.
    localparam int RS_W = 256;

    typedef struct packed {
        logic                   ovf;
        logic signed [RS_W-1:0] val;
    } rs_t;

    // Round half toward +inf, arithmetic shift, then range check / clamp to out_w.
    function automatic rs_t round_shift_sat(input logic signed [RS_W-1:0] acc,
                                            input int frac_shift,
                                            input int out_w,
                                            input bit sat_en);
        logic signed [RS_W-1:0] one, r, hi, lo;
        rs_t res;
        one = {{(RS_W-1){1'b0}}, 1'b1};
        r = acc;
        if (frac_shift > 0)
            r = (acc + (one <<< (frac_shift - 1))) >>> frac_shift;
        hi = (one <<< (out_w - 1)) - one;
        lo = -(one <<< (out_w - 1));
        res.ovf = (r > hi) || (r < lo);
        res.val = r;
        if (sat_en && (r > hi))
            res.val = hi;
        else if (sat_en && (r < lo))
            res.val = lo;
        return res;
    endfunction

endpackage

// File: rtl/predictor_mac_mul_pipe.sv
// Operand registers plus MUL_STAGES signed product registers with valid/last sideband.
module predictor_mac_mul_pipe
    import predictor_mac_pkg::*;
#(
    parameter int A_W        = PRED_A_W,
    parameter int B_W        = PRED_B_W,
    parameter int MUL_STAGES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   din0,
    input  logic signed [B_W-1:0]   din1,
    output logic signed [A_W+B_W-1:0] prod,
    output logic                    prod_valid,
    output logic                    prod_last
);

    localparam int P_W = A_W + B_W;

    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic signed [P_W-1:0] mul;
    logic signed [P_W-1:0] prod_pipe [1:MUL_STAGES];
    // Index 0 tracks the operand registers, index k the k-th product register.
    logic [MUL_STAGES:0]   vld_pipe;
    logic [MUL_STAGES:0]   last_pipe;

    assign mul = P_W'(a_q) * P_W'(b_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int i = 1; i <= MUL_STAGES; i++)
                prod_pipe[i] <= '0;
        end else if (ce) begin
            a_q          <= din0;
            b_q          <= din1;
            vld_pipe     <= {vld_pipe[MUL_STAGES-1:0], in_valid};
            last_pipe    <= {last_pipe[MUL_STAGES-1:0], in_valid & in_last};
            prod_pipe[1] <= mul;
            for (int i = 2; i <= MUL_STAGES; i++)
                prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    assign prod       = prod_pipe[MUL_STAGES];
    assign prod_valid = vld_pipe[MUL_STAGES];
    assign prod_last  = last_pipe[MUL_STAGES];

endmodule

// File: rtl/predictor_mac_pipe.sv
// Framed signed multiply-accumulate: product pipe, frame accumulator, rounded/saturated result.
module predictor_mac_pipe
    import predictor_mac_pkg::*;
#(
    parameter int A_W        = PRED_A_W,
    parameter int B_W        = PRED_B_W,
    parameter int MUL_STAGES = 4,
    parameter int ACC_W      = PRED_ACC_W,
    parameter int OUT_W      = 64,
    parameter int FRAC_SHIFT = 28,
    parameter bit SAT_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   din0,
    input  logic signed [B_W-1:0]   din1,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    out_ovf
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic                    prod_valid;
    logic                    prod_last;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic                    first;
    logic                    acc_last;
    rs_t                     rs;
    logic                    unused_hi;

    predictor_mac_mul_pipe #(
        .A_W        (A_W),
        .B_W        (B_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .din0       (din0),
        .din1       (din1),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_last  (prod_last)
    );

    assign prod_ext  = ACC_W'(prod);
    assign rs        = round_shift_sat(RS_W'(acc), FRAC_SHIFT, OUT_W, SAT_EN);
    assign unused_hi = ^rs.val[RS_W-1:OUT_W];

    // acc_last marks that acc now holds a complete frame; the result is taken one ce-edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            first     <= 1'b1;
            acc_last  <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            acc_last  <= prod_valid & prod_last;
            out_valid <= acc_last;
            if (prod_valid) begin
                acc   <= first ? prod_ext : acc + prod_ext;
                first <= prod_last;
            end
            if (acc_last) begin
                dout    <= rs.val[OUT_W-1:0];
                out_ovf <= rs.ovf;
            end
        end
    end

endmodule

// File: tb/tb_predictor_mac_pipe.sv
// Four parameter variants share one stimulus stream; a frame-level model scores every cycle.
module tb_predictor_mac_pipe;

    localparam int M = 4;
    localparam int FS  [4] = '{0, 4, 0, 0};
    localparam int OW  [4] = '{64, 64, 16, 16};
    localparam bit SAT [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               ce = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic signed [28:0] din0 = '0;
    logic signed [63:0] din1 = '0;

    logic               ov [4];
    logic               oo [4];
    logic signed [63:0] d0, d1;
    logic signed [15:0] d2, d3;
    logic signed [63:0] dv [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    predictor_mac_pipe #(.FRAC_SHIFT(0)) u0 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov[0]), .dout(d0), .out_ovf(oo[0]));
    predictor_mac_pipe #(.FRAC_SHIFT(4)) u1 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov[1]), .dout(d1), .out_ovf(oo[1]));
    predictor_mac_pipe #(.OUT_W(16), .SAT_EN(1'b1), .FRAC_SHIFT(0)) u2 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov[2]), .dout(d2),
        .out_ovf(oo[2]));
    predictor_mac_pipe #(.OUT_W(16), .SAT_EN(1'b0), .FRAC_SHIFT(0)) u3 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov[3]), .dout(d3),
        .out_ovf(oo[3]));

    assign dv[0] = d0;
    assign dv[1] = d1;
    assign dv[2] = {{48{d2[15]}}, d2};
    assign dv[3] = {{48{d3[15]}}, d3};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        int                 due;
        logic signed [63:0] v [4];
        bit                 o [4];
    } exp_t;

    exp_t                q[$];
    int                  ce_cnt = 0;
    bit                  m_first = 1'b1;
    logic signed [127:0] m_sum = '0;

    function automatic void exp_res(input logic signed [127:0] s, input int fs, input int ow, input bit sat,
                                    output logic signed [63:0] v, output bit o);
        logic signed [127:0] r, hi, lo;
        r = s;
        if (fs > 0) r = (s + (128'sd1 <<< (fs - 1))) >>> fs;
        hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        o = (r > hi) || (r < lo);
        if (sat) begin
            if (r > hi) r = hi;
            else if (r < lo) r = lo;
        end else begin
            r = (r <<< (128 - ow)) >>> (128 - ow);
        end
        v = r[63:0];
    endfunction

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            q.delete();
            m_first = 1'b1;
            m_sum = '0;
        end else if (ce) begin
            ce_cnt++;
            while (q.size() > 0 && q[0].due < ce_cnt) void'(q.pop_front());
            if (in_valid) begin
                logic signed [127:0] a, b;
                a = din0;
                b = din1;
                m_sum = m_first ? a * b : m_sum + a * b;
                m_sum = (m_sum <<< 28) >>> 28;
                m_first = in_last;
                if (in_last) begin
                    exp_t e;
                    e.due = ce_cnt + M + 2;
                    for (int i = 0; i < 4; i++) exp_res(m_sum, FS[i], OW[i], SAT[i], e.v[i], e.o[i]);
                    q.push_back(e);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rst_valid[%0d]", i), ov[i], 0);
                chk($sformatf("rst_dout[%0d]", i), dv[i], 0);
                chk($sformatf("rst_ovf[%0d]", i), oo[i], 0);
            end
        end else begin
            bit ev;
            ev = (q.size() > 0) && (q[0].due == ce_cnt);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid[%0d]", i), ov[i], ev);
                if (ev) begin
                    chk($sformatf("dout[%0d]", i), dv[i], q[0].v[i]);
                    chk($sformatf("out_ovf[%0d]", i), oo[i], q[0].o[i]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input longint a, input longint b, input bit last);
        @(negedge clk);
        ce = 1'b1;
        in_valid = 1'b1;
        in_last = last;
        din0 = 29'(a);
        din1 = b;
    endtask

    task automatic idle();
        @(negedge clk);
        ce = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic stall(input int n);
        @(negedge clk);
        ce = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!ov[0] && n < 40);
        chk("wait_out_valid", ov[0], 1);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", ov[0], 0);
        chk("reset_dout", d0, 0);
        reset = 1'b1;

        // single beat: latency and value
        send(3, -5, 1'b1);
        idle();
        wait_valid(n);
        chk("single_latency", n, 6);
        chk("single_dout", d0, -15);
        chk("single_ovf", oo[0], 0);

        // four-beat dot product followed directly by a single-beat frame
        send(1, 10, 1'b0);
        send(2, 20, 1'b0);
        send(-3, 30, 1'b0);
        send(4, 40, 1'b1);
        send(7, 7, 1'b1);
        idle();
        wait_valid(n);
        chk("dot4_dout", d0, 120);
        @(negedge clk);
        #1;
        chk("b2b_valid", ov[0], 1);
        chk("b2b_dout", d0, 49);
        @(negedge clk);
        #1;
        chk("b2b_pulse_end", ov[0], 0);

        // rounding half toward +inf with FRAC_SHIFT=4
        send(1, 24, 1'b1);
        idle();
        wait_valid(n);
        chk("round_pos", d1, 2);
        send(1, -24, 1'b1);
        idle();
        wait_valid(n);
        chk("round_neg", d1, -1);

        // 16-bit result: clamp versus truncate
        send(300, 300, 1'b1);
        idle();
        wait_valid(n);
        chk("sat_dout", dv[2], 32767);
        chk("sat_ovf", oo[2], 1);
        chk("trunc_dout", dv[3], 24464);
        chk("trunc_ovf", oo[3], 1);

        // ce stall mid-frame and while the result is presented
        send(2, 3, 1'b0);
        stall(3);
        send(4, 5, 1'b1);
        idle();
        wait_valid(n);
        chk("stall_dout", d0, 26);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stall_hold_valid", ov[0], 1);
            chk("stall_hold_dout", d0, 26);
        end
        ce = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_release", ov[0], 0);

        // reset in the middle of a frame
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        #1;
        chk("midrst_valid", ov[0], 0);
        chk("midrst_dout", d0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(5, 5, 1'b1);
        idle();
        wait_valid(n);
        chk("after_rst_dout", d0, 25);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
